// File: rtl/vga_mem_pkg.sv
// Shared definitions for the VGA/CPU memory-port arbiter: state encoding,
// default bus widths and the fairness-counter helper.
package vga_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 72;
    localparam int RUN_W      = 4;
    localparam int WD_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VGA_ACC = 2'd1,
        CPU_ACC = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v,
                                                 input logic [RUN_W-1:0] max);
        return (v >= max) ? max : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Loadable cycle counter with clear and enable; o_expire pulses in the cycle
// whose increment would bring the count to i_limit.
module arb_watchdog #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;
    logic [W:0]   w_cnt_inc;

    // One extra bit so a limit at the top of the range never wraps the compare.
    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
    assign o_expire  = i_en && (w_cnt_inc == {1'b0, i_limit});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= w_cnt_inc[W-1:0];
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port memory arbiter: VGA has priority, a run counter bounds CPU
// starvation, and a watchdog aborts accesses the memory never completes.
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int MAX_VGA_RUN = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vga_rq,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic              o_vga_ack,
    output logic [DATA_W-1:0] o_vga_data,
    input  logic              i_cpu_rq,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_timeout_err
);

    localparam logic [RUN_W-1:0] MAX_RUN  = RUN_W'(MAX_VGA_RUN);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

    arb_state_t        r_state, w_next;
    logic [RUN_W-1:0]  r_run_cnt;
    logic              r_vga_ack, r_cpu_ack, r_timeout_err;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_vga_data, r_cpu_rdata;

    logic w_acc, w_vga_win, w_grant_vga, w_grant_cpu;
    logic w_wd_en, w_wd_exp, w_finish, w_abort;

    assign w_acc       = (r_state == VGA_ACC) || (r_state == CPU_ACC);
    assign w_vga_win   = i_vga_rq && (!i_cpu_rq || (r_run_cnt < MAX_RUN));
    assign w_grant_vga = (r_state == IDLE) && w_vga_win;
    assign w_grant_cpu = (r_state == IDLE) && !w_vga_win && i_cpu_rq;

    // mem_ready wins over an expiry landing in the same cycle.
    assign w_wd_en  = w_acc && !i_mem_ready;
    assign w_finish = w_acc && (i_mem_ready || w_wd_exp);
    assign w_abort  = w_wd_en && w_wd_exp;

    arb_watchdog #(.W(WD_W)) u_watchdog (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (!w_acc),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_wd_en),
        .i_limit    (WD_LIMIT),
        .o_expire   (w_wd_exp)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_vga)      w_next = VGA_ACC;
                else if (w_grant_cpu) w_next = CPU_ACC;
            end
            VGA_ACC, CPU_ACC: if (w_finish) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_vga_ack     <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_vga_data    <= '0;
            r_cpu_rdata   <= '0;
            r_timeout_err <= 1'b0;
            r_run_cnt     <= '0;
        end else begin
            r_vga_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            if (w_grant_vga) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_vga_addr;
                r_mem_wdata <= '0;
            end else if (w_grant_cpu) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= i_cpu_we;
                r_mem_addr  <= i_cpu_addr;
                r_mem_wdata <= i_cpu_wdata;
            end
            if (w_finish) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (w_abort) r_timeout_err <= 1'b1;
                if (r_state == VGA_ACC) begin
                    r_vga_ack <= 1'b1;
                    if (i_mem_ready) r_vga_data <= i_mem_rdata;
                    // Only VGA grants made while the CPU waits count toward starvation.
                    r_run_cnt <= i_cpu_rq ? sat_inc(r_run_cnt, MAX_RUN) : '0;
                end else begin
                    r_cpu_ack <= 1'b1;
                    if (i_mem_ready && !r_mem_we) r_cpu_rdata <= i_mem_rdata;
                    r_run_cnt <= '0;
                end
            end
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_vga_ack     = r_vga_ack;
    assign o_cpu_ack     = r_cpu_ack;
    assign o_vga_data    = r_vga_data;
    assign o_cpu_rdata   = r_cpu_rdata;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed plus randomized bench for vga_mem_arbiter; a grant/run-count model
// predicts every grantee, ack and data value.
module tb_vga_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 72;
    localparam int MAXR = 4;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_rq, cpu_rq, cpu_we, mem_ready;
    logic [AW-1:0] vga_addr, cpu_addr;
    logic [DW-1:0] cpu_wdata, mem_rdata;
    logic          vga_ack, cpu_ack, mem_req, mem_we, timeout_err;
    logic [DW-1:0] vga_data, cpu_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            m_run;
    logic [DW-1:0] m_vdata, m_cdata;
    string         ord;

    always #5 clk = ~clk;

    vga_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_VGA_RUN(MAXR), .TIMEOUT(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_vga_rq(vga_rq), .i_vga_addr(vga_addr), .o_vga_ack(vga_ack), .o_vga_data(vga_data),
        .i_cpu_rq(cpu_rq), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .o_timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete grant. Called with the arbiter idle; returns one cycle
    // after the ack, with the arbiter back in IDLE.
    task automatic txn(input logic v, input logic c, input logic we,
                       input logic [AW-1:0] va, input logic [AW-1:0] ca,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                       input int lat, input logic drop);
        logic gv;
        vga_rq = v; vga_addr = va;
        cpu_rq = c; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
        gv = v && (!c || m_run < MAXR);
        step();
        chk("mem_req_rise", DW'(mem_req), DW'(1'b1));
        chk("mem_addr", DW'(mem_addr), DW'(gv ? va : ca));
        chk("mem_we", DW'(mem_we), DW'(gv ? 1'b0 : we));
        if (!gv && we) chk("mem_wdata", mem_wdata, wd);
        for (int i = 0; i < lat; i++) begin
            step();
            chk("mem_req_held", DW'(mem_req), DW'(1'b1));
            chk("no_early_ack", DW'(vga_ack | cpu_ack), DW'(1'b0));
        end
        mem_ready = 1'b1; mem_rdata = rd;
        step();
        mem_ready = 1'b0;
        if (gv) begin
            m_vdata = rd;
            m_run   = c ? ((m_run + 1 > MAXR) ? MAXR : m_run + 1) : 0;
        end else begin
            if (!we) m_cdata = rd;
            m_run = 0;
        end
        chk("vga_ack", DW'(vga_ack), DW'(gv));
        chk("cpu_ack", DW'(cpu_ack), DW'(!gv));
        chk("mem_req_drop", DW'(mem_req), DW'(1'b0));
        chk("vga_data", vga_data, m_vdata);
        chk("cpu_rdata", cpu_rdata, m_cdata);
        if (vga_ack) ord = {ord, "V"};
        else         ord = {ord, "C"};
        if (drop) begin vga_rq = 1'b0; cpu_rq = 1'b0; end
        step();
        chk("ack_one_cycle", DW'(vga_ack | cpu_ack), DW'(1'b0));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; vga_rq = 1'b0; cpu_rq = 1'b0; cpu_we = 1'b0; mem_ready = 1'b0;
        vga_addr = '0; cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
        m_run = 0; m_vdata = '0; m_cdata = '0; ord = "";
        #12;
        chk("rst_mem_req", DW'(mem_req), DW'(1'b0));
        chk("rst_mem_we", DW'(mem_we), DW'(1'b0));
        chk("rst_mem_addr", DW'(mem_addr), DW'(0));
        chk("rst_mem_wdata", mem_wdata, DW'(0));
        chk("rst_acks", DW'({vga_ack, cpu_ack}), DW'(0));
        chk("rst_vga_data", vga_data, DW'(0));
        chk("rst_cpu_rdata", cpu_rdata, DW'(0));
        chk("rst_timeout_err", DW'(timeout_err), DW'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single VGA read, ready two cycles after the request appears.
        txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, '0, 72'hABCDEF, 2, 1'b1);
        // CPU write with immediate ready; cpu_rdata must not move.
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 72'd5, 72'hDEAD_BEEF, 0, 1'b1);

        // Stray mem_ready with nothing pending.
        mem_ready = 1'b1; mem_rdata = 72'h55;
        step();
        mem_ready = 1'b0;
        chk("stray_no_ack", DW'(vga_ack | cpu_ack), DW'(1'b0));
        chk("stray_no_req", DW'(mem_req), DW'(1'b0));
        step();
        chk("stray_still_idle", DW'({mem_req, vga_ack, cpu_ack}), DW'(0));

        // Both requesters held: fairness cap forces every fifth grant to CPU.
        ord = "";
        for (int i = 0; i < 10; i++)
            txn(1'b1, 1'b1, 1'b0, AW'(32'h1000 + i), AW'(32'h2000 + i), '0,
                DW'({$urandom(), $urandom(), $urandom()}), i % 3, 1'b0);
        vga_rq = 1'b0; cpu_rq = 1'b0;
        n_assert++;
        assert (ord == "VVVVCVVVVC") else begin
            n_fail++;
            $error("FAIL grant_order: observed %s expected VVVVCVVVVC", ord);
        end

        // Timeout: CPU read that memory never answers.
        cpu_rq = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req) n++;
            else break;
        end
        chk("to_req_cycles", DW'(n), DW'(TMO));
        chk("to_cpu_ack", DW'(cpu_ack), DW'(1'b1));
        chk("to_vga_ack", DW'(vga_ack), DW'(1'b0));
        chk("to_err_set", DW'(timeout_err), DW'(1'b1));
        chk("to_rdata_kept", cpu_rdata, m_cdata);
        m_run = 0;
        cpu_rq = 1'b0;
        step();
        chk("to_err_sticky", DW'(timeout_err), DW'(1'b1));
        chk("to_ack_pulse", DW'(cpu_ack), DW'(1'b0));
        txn(1'b1, 1'b0, 1'b0, 32'h180, 32'h0, '0, 72'h123456, 1, 1'b1);
        chk("to_err_after_vga", DW'(timeout_err), DW'(1'b1));

        // Reset one cycle after mem_req rises.
        vga_rq = 1'b1; vga_addr = 32'h300; cpu_rq = 1'b0;
        step();
        chk("rstmid_req_up", DW'(mem_req), DW'(1'b1));
        step();
        rst_n = 1'b0;
        #1;
        chk("rstmid_req_async", DW'(mem_req), DW'(1'b0));
        chk("rstmid_err_clr", DW'(timeout_err), DW'(1'b0));
        m_run = 0; m_vdata = '0; m_cdata = '0;
        @(negedge clk);
        chk("rstmid_no_ack", DW'(vga_ack | cpu_ack), DW'(1'b0));
        rst_n = 1'b1;
        txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, '0, 72'hFACE, 0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic v, c;
            v = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            if (!v && !c) v = 1'b1;
            txn(v, c, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                DW'({$urandom(), $urandom(), $urandom()}),
                DW'({$urandom(), $urandom(), $urandom()}),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        vga_rq = 1'b0; cpu_rq = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
